// File: rtl/axi4_master_read_burst_if.sv
// AXI4 read-address and read-data channel bundle between a read master and its slave.
interface axi4_master_read_burst_if #(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4
);
  logic                      AR_READY;
  logic                      AR_VALID;
  logic [AXI_ADDR_WIDTH-1:0] AR_ADDR;
  logic [7:0]                AR_LEN;
  logic [2:0]                AR_SIZE;
  logic [1:0]                AR_BURST;
  logic [AXI_ID_WIDTH-1:0]   AR_ID;
  logic [2:0]                AR_PROT;

  logic [AXI_DATA_WIDTH-1:0] R_DATA;
  logic [1:0]                R_RESP;
  logic                      R_LAST;
  logic [AXI_ID_WIDTH-1:0]   R_ID;
  logic                      R_VALID;
  logic                      R_READY;

  modport master (
    input  AR_READY, R_DATA, R_RESP, R_LAST, R_ID, R_VALID,
    output AR_VALID, AR_ADDR, AR_LEN, AR_SIZE, AR_BURST, AR_ID, AR_PROT, R_READY
  );

  modport slave (
    output AR_READY, R_DATA, R_RESP, R_LAST, R_ID, R_VALID,
    input  AR_VALID, AR_ADDR, AR_LEN, AR_SIZE, AR_BURST, AR_ID, AR_PROT, R_READY
  );
endinterface

// File: rtl/axi4_master_read_burst.sv
// AXI4 INCR read-burst master; R beats pass combinationally to the consumer, which backpressures via R_READY.
// Define AXI_READ_4K_SPLIT_EN to split a burst crossing a 4 KiB boundary into two AR requests.
module axi4_master_read_burst #(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int READ_ID        = 0
) (
  input  logic                      clk_i,
  input  logic                      arst_i,
  input  logic [AXI_ADDR_WIDTH-1:0] addr_i,
  input  logic [7:0]                len_i,
  input  logic                      start_read_i,
  output logic                      busy_o,
  output logic [AXI_DATA_WIDTH-1:0] data_o,
  output logic                      data_valid_o,
  input  logic                      data_ready_i,
  output logic                      access_fault_o,
  output logic                      done_o,
  axi4_master_read_burst_if.master  axi
);

  localparam int                        SIZE_LOG2 = $clog2(AXI_DATA_WIDTH / 8);
  localparam logic [AXI_ID_WIDTH-1:0]   RID       = AXI_ID_WIDTH'(READ_ID);
  localparam logic [AXI_ADDR_WIDTH-1:0] LOW_MASK  = AXI_ADDR_WIDTH'(AXI_DATA_WIDTH / 8 - 1);

  typedef enum logic [1:0] {IDLE, AR_SEND, READ, RESP} state_t;

  state_t                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr_q;
  logic [7:0]                ar_len_q;
  logic [7:0]                beat_cnt_q;
  logic                      fault_q;

  logic                      ar_valid, r_ready, dvalid, done, busy;
  logic                      start_acc, beat_acc, last_beat, beat_bad;
  logic [AXI_ADDR_WIDTH-1:0] addr_aligned;
  logic [7:0]                first_len;
  logic                      split_pend;
  logic                      unused_resp_lsb;

  assign addr_aligned    = addr_i & ~LOW_MASK;
  assign start_acc       = (state_q == IDLE) && start_read_i;
  assign beat_acc        = (state_q == READ) && axi.R_VALID && data_ready_i;
  assign last_beat       = (beat_cnt_q == ar_len_q);
  assign beat_bad        = (axi.R_LAST != last_beat) || (axi.R_ID != RID) || axi.R_RESP[1];
  assign unused_resp_lsb = axi.R_RESP[0];

`ifdef AXI_READ_4K_SPLIT_EN
  logic                      split_pend_q;
  logic [AXI_ADDR_WIDTH-1:0] split_addr_q;
  logic [7:0]                split_len_q;
  logic [12:0]               bytes_to_4k;
  logic [12:0]               beats_to_4k;
  logic [8:0]                total_beats;
  logic                      crosses;
  logic [AXI_ADDR_WIDTH-1:0] boundary;

  // Aligned start plus at most 4 KiB of data means at most one crossing.
  assign bytes_to_4k = 13'h1000 - {1'b0, addr_aligned[11:0]};
  assign beats_to_4k = bytes_to_4k >> SIZE_LOG2;
  assign total_beats = {1'b0, len_i} + 9'd1;
  assign crosses     = ({4'b0000, total_beats} > beats_to_4k);
  assign boundary    = {addr_aligned[AXI_ADDR_WIDTH-1:12]
                        + {{(AXI_ADDR_WIDTH-13){1'b0}}, 1'b1}, 12'h000};
  assign first_len   = crosses ? 8'(beats_to_4k - 13'd1) : len_i;
  assign split_pend  = split_pend_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      split_pend_q <= 1'b0;
      split_addr_q <= '0;
      split_len_q  <= '0;
    end else if (start_acc) begin
      split_pend_q <= crosses;
      split_addr_q <= boundary;
      split_len_q  <= 8'(total_beats - beats_to_4k[8:0] - 9'd1);
    end else if (beat_acc && last_beat) begin
      split_pend_q <= 1'b0;
    end
  end
`else
  assign first_len  = len_i;
  assign split_pend = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ar_valid = 1'b0;
    r_ready  = 1'b0;
    dvalid   = 1'b0;
    done     = 1'b0;
    busy     = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start_read_i) state_d = AR_SEND;
      end
      AR_SEND: begin
        ar_valid = 1'b1;
        if (axi.AR_READY) state_d = READ;
      end
      READ: begin
        r_ready = data_ready_i;
        dvalid  = axi.R_VALID;
        // A pending second half of a split burst loops back for another AR.
        if (beat_acc && last_beat) state_d = split_pend ? AR_SEND : RESP;
      end
      RESP: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      beat_cnt_q <= '0;
      fault_q    <= 1'b0;
    end else if (start_acc) begin
      ar_addr_q  <= addr_aligned;
      ar_len_q   <= first_len;
      beat_cnt_q <= '0;
      fault_q    <= 1'b0;
    end else if (beat_acc) begin
      fault_q <= fault_q | beat_bad;
      if (last_beat) begin
        beat_cnt_q <= '0;
`ifdef AXI_READ_4K_SPLIT_EN
        if (split_pend_q) begin
          ar_addr_q <= split_addr_q;
          ar_len_q  <= split_len_q;
        end
`endif
      end else begin
        beat_cnt_q <= beat_cnt_q + 8'd1;
      end
    end
  end

  assign axi.AR_VALID = ar_valid;
  assign axi.AR_ADDR  = ar_addr_q;
  assign axi.AR_LEN   = ar_len_q;
  assign axi.AR_SIZE  = 3'(SIZE_LOG2);
  assign axi.AR_BURST = 2'b01;
  assign axi.AR_ID    = RID;
  assign axi.AR_PROT  = 3'b000;
  assign axi.R_READY  = r_ready;

  assign data_o         = axi.R_DATA;
  assign data_valid_o   = dvalid;
  assign done_o         = done;
  assign busy_o         = busy;
  assign access_fault_o = fault_q;

endmodule

// File: doc/axi4_master_read_burst.md
AXI4_MASTER_READ_BURST -- requirements
Module: axi4_master_read_burst

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 64, address width.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 32, data width; legal values 32/64/128.
REQ-003 SHALL have parameter AXI_ID_WIDTH, default 4, ID width.
REQ-004 SHALL have parameter READ_ID, default 0, constant ARID driven on every request.
REQ-005 SHALL have ports: clk_i in 1 clock; arst_i in 1 reset. One clock; reset asynchronous, active-high.
REQ-006 SHALL have ports: addr_i in AXI_ADDR_WIDTH start address; len_i in 8 beats-1; start_read_i in 1 request strobe; busy_o out 1 not idle.
REQ-007 SHALL have ports: data_o out AXI_DATA_WIDTH beat data; data_valid_o out 1 beat valid; data_ready_i in 1 consumer ready; access_fault_o out 1 sticky error; done_o out 1 completion pulse.
REQ-008 SHALL have AXI AR ports: AR_READY in 1; AR_VALID out 1; AR_ADDR out AXI_ADDR_WIDTH; AR_LEN out 8; AR_SIZE out 3; AR_BURST out 2; AR_ID out AXI_ID_WIDTH; AR_PROT out 3.
REQ-009 SHALL have AXI R ports: R_DATA in AXI_DATA_WIDTH; R_RESP in 2; R_LAST in 1; R_ID in AXI_ID_WIDTH; R_VALID in 1; R_READY out 1.

Function
REQ-010 SHALL implement FSM IDLE, AR_SEND, READ, RESP.
REQ-011 IDLE->AR_SEND when start_read_i=1; addr_i (low log2(AXI_DATA_WIDTH/8) bits forced 0) and len_i captured that edge; start_read_i ignored outside IDLE.
REQ-012 AR_VALID SHALL be 1 exactly in AR_SEND, from the cycle after the accepted start; AR_ADDR/AR_LEN stable while AR_VALID=1.
REQ-013 AR_SEND->READ on AR_VALID&AR_READY; AR_VALID deasserts the following cycle.
REQ-014 AR_SIZE SHALL be log2(AXI_DATA_WIDTH/8), AR_BURST 2'b01 (INCR), AR_ID READ_ID, AR_PROT 3'b000, constant.
REQ-015 In READ: R_READY = data_ready_i; data_valid_o = R_VALID; data_o = R_DATA (combinational pass-through, zero latency); R_READY=0 in all other states.
REQ-016 Beat accepted on R_VALID&R_READY; internal beat counter counts accepted beats of current burst.
REQ-017 Last beat = counter equals AR_LEN of current burst; READ->RESP on last accepted beat (or AR_SEND per REQ-026).
REQ-018 R_LAST mismatching last-beat condition, or R_ID != READ_ID on an accepted beat, SHALL set access_fault_o; FSM still follows the beat counter.
REQ-019 Accepted beat with R_RESP[1]=1 (SLVERR/DECERR) SHALL set access_fault_o.
REQ-020 access_fault_o cleared when a new start is accepted in IDLE; holds through RESP and IDLE until then.
REQ-021 RESP lasts one cycle; done_o=1 only in RESP; RESP->IDLE unconditionally.
REQ-022 busy_o=1 in every state except IDLE.
REQ-023 data_ready_i=0 stalls READ indefinitely with no beat loss; R_VALID without data_ready_i produces no count.

Reset
REQ-024 arst_i=1 SHALL force IDLE, AR_VALID=0, R_READY=0, AR_ADDR=0, AR_LEN=0, counter=0, access_fault_o=0, done_o=0, busy_o=0, data_valid_o=0 immediately, including mid-burst; no request resumes after release.
REQ-025 First start after reset release SHALL be accepted on the first rising edge with arst_i=0.

Configuration
REQ-026 Macro AXI_READ_4K_SPLIT_EN defined: if the burst crosses a 4 KiB boundary, first AR covers beats up to the boundary, second AR (address = boundary, remaining length) issued after the first burst's last beat via READ->AR_SEND; done_o only after the final beat; access_fault_o accumulates across both.
REQ-027 Macro undefined: single AR issued as given; caller guarantees no 4 KiB crossing; no split logic synthesized.

Verification
REQ-028 Reset: arst_i=1 -> all outputs 0, state IDLE; release then start addr 0x1000 len 0 -> AR_VALID next cycle, AR_ADDR 0x1000, AR_LEN 0, done_o after one beat.
REQ-029 Burst: addr 0x2000 len 3, slave returns 0xA0..0xA3 OKAY, R_LAST on 4th -> four data_valid_o beats in order, done_o one cycle, access_fault_o 0.
REQ-030 Backpressure: len 3, data_ready_i low 5 cycles after beat 1 -> R_READY low during stall, no beats lost, done_o after 4th beat.
REQ-031 Error: len 1, beat 0 R_RESP=2'b10 -> access_fault_o 1 through done_o and IDLE; cleared on next accepted start.
REQ-032 Reset mid-burst: arst_i asserted after beat 2 of len 7 -> AR_VALID/R_READY/busy_o 0 immediately, no done_o.
REQ-033 With AXI_READ_4K_SPLIT_EN, 32-bit data: addr 0x0FF8 len 3 -> AR 0x0FF8 len 1, then AR 0x1000 len 1, single done_o after 4 beats.
